// File: rtl/alu_pkg.sv
// Shared types for the ALU writeback stage: flag register layout, FIFO entry and the
// hardwired zero register index.
package alu_pkg;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_entry_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/alu_wb_fifo.sv
// Small valid/ready FIFO of writeback entries. DEPTH must be 2 or 4 so pointers wrap
// naturally; ready depends on registered state only.
module alu_wb_fifo
   import alu_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push_valid_i,
   output logic      push_ready_o,
   input  wb_entry_t push_data_i,
   output logic      pop_valid_o,
   input  logic      pop_ready_i,
   output wb_entry_t pop_data_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   wb_entry_t     mem_q [DEPTH];
   logic          push, pop;

   assign push_ready_o = (count_q != CW'(DEPTH));
   assign pop_valid_o  = (count_q != '0);
   assign pop_data_o   = mem_q[rd_ptr_q];
   assign push         = push_valid_i && push_ready_o;
   assign pop          = pop_valid_o && pop_ready_i;

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push) begin
            mem_q[wr_ptr_q] <= push_data_i;
         end
      end
   end

`ifndef SYNTHESIS
   assert property (@(posedge clk) disable iff (!rst_n) pop |-> (count_q != '0));
   assert property (@(posedge clk) disable iff (!rst_n) push |-> (count_q != CW'(DEPTH)));
`endif

endmodule

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: buffers results toward the register file and keeps the NZCV flags
// plus a sticky overflow. Define ALU_WB_CARRY_BYPASS_EN to forward in_carry to carry_in.
module alu_wb_stage
   import alu_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_result,
   input  logic [4:0]  in_rd,
   input  logic        in_we,
   input  logic        in_flag_we,
   input  logic        in_carry,
   input  logic        in_overflow,
   input  logic        in_zero,
   input  logic        in_neg,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [4:0]  wb_addr,
   output logic [31:0] wb_data,
   output logic [3:0]  flags,
   output logic        carry_in,
   output logic        ovf_sticky,
   input  logic        clr_sticky
);

   flags_t    flags_q, flags_d;
   logic      sticky_q, sticky_d;
   logic      accept, push_valid, flag_commit;
   wb_entry_t push_entry, head_entry;

   assign accept      = in_valid && in_ready;
   assign flag_commit = accept && in_flag_we;
   // Writes to the zero register are dropped here; flags still commit below.
   assign push_valid  = accept && in_we && (in_rd != REG_ZERO);
   assign push_entry  = '{rd: in_rd, data: in_result};

   alu_wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_valid_i (push_valid),
      .push_ready_o (in_ready),
      .push_data_i  (push_entry),
      .pop_valid_o  (wb_valid),
      .pop_ready_i  (wb_ready),
      .pop_data_o   (head_entry)
   );

   assign wb_addr = head_entry.rd;
   assign wb_data = head_entry.data;

   always_comb begin
      flags_d  = flags_q;
      sticky_d = sticky_q;
      if (flag_commit) begin
         flags_d = '{n: in_neg, z: in_zero, c: in_carry, v: in_overflow};
      end
      if (flag_commit && in_overflow) begin
         sticky_d = 1'b1;
      end else if (clr_sticky) begin
         sticky_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q  <= '0;
         sticky_q <= 1'b0;
      end else begin
         flags_q  <= flags_d;
         sticky_q <= sticky_d;
      end
   end

   assign flags      = flags_q;
   assign ovf_sticky = sticky_q;

`ifdef ALU_WB_CARRY_BYPASS_EN
   assign carry_in = (in_valid && in_flag_we) ? in_carry : flags_q.c;
`else
   assign carry_in = flags_q.c;
`endif

endmodule
